// File: rtl/module_hamming_secded_stream_pkg.sv
// Shared SECDED helpers: code geometry, data-position mapping and the
// error classification type used by the streaming decoder.
package pkg_secded;

    localparam int MAX_CW = 64;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SINGLE,
        ERR_DOUBLE
    } err_class_t;

    function automatic int par_w(input int data_w);
        int r;
        r = 1;
        while ((1 << r) < data_w + r + 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Data bits live in the non-power-of-two positions, lowest position first.
    function automatic logic [MAX_CW-1:0] extract_data(input logic [MAX_CW-1:0] cw,
                                                        input int cw_w);
        logic [MAX_CW-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int k = 1; k < MAX_CW; k++) begin
            if (k < cw_w && !is_pow2(k)) begin
                d[j] = cw[k];
                j++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/module_hamming_secded_stream_syndrome.sv
// Combinational Hamming syndrome and overall parity of an extended codeword.
// Bit 0 is the overall parity bit; bit k carries Hamming position k.
module module_secded_syndrome #(
    parameter int CW_W = 8,
    localparam int SYN_W = $clog2(CW_W)
) (
    input  logic [CW_W-1:0]  codeword_i,
    output logic [SYN_W-1:0] syndrome_o,
    output logic             parity_o
);

    always_comb begin
        syndrome_o = '0;
        for (int k = 1; k < CW_W; k++) begin
            if (codeword_i[k]) begin
                syndrome_o = syndrome_o ^ SYN_W'(k);
            end
        end
        parity_o = ^codeword_i;
    end

endmodule

// File: rtl/module_hamming_secded_stream.sv
// Two-stage SECDED decoder/corrector for a valid/ready codeword stream,
// with detect-only mode and saturating error counters.
module module_hamming_secded_stream
    import pkg_secded::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8,
    localparam int PAR_W = par_w(DATA_W),
    localparam int CW_W  = DATA_W + PAR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CW_W-1:0]   codeword_i,
    input  logic              corr_en_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              err_single_o,
    output logic              err_double_o,
    output logic [PAR_W-1:0]  syndrome_o,
    output logic [CNT_W-1:0]  cnt_corr_o,
    output logic [CNT_W-1:0]  cnt_uncorr_o,
    input  logic              clr_cnt_i
);

    logic              s1_valid;
    logic              s1_corr_en;
    logic              s1_parity;
    logic [CW_W-1:0]   s1_cw;
    logic [PAR_W-1:0]  s1_syn;

    logic [PAR_W-1:0]  in_syn;
    logic              in_parity;

    logic              s2_open;
    logic              s1_advance;
    logic              in_fire;
    logic              out_fire;

    err_class_t        s1_class;
    logic [CW_W-1:0]   corr_cw;
    logic [DATA_W-1:0] s1_data;

    module_secded_syndrome #(
        .CW_W(CW_W)
    ) u_syndrome (
        .codeword_i(codeword_i),
        .syndrome_o(in_syn),
        .parity_o  (in_parity)
    );

    // Handshake: a transfer happens on a cycle where valid and ready are both
    // high; valid never waits on ready, and a stage loads when empty or when
    // its current word leaves in the same cycle.
    assign s2_open    = !out_valid_o || out_ready_i;
    assign s1_advance = s1_valid && s2_open;
    assign in_ready_o = !s1_valid || s1_advance;
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid   <= 1'b0;
            s1_corr_en <= 1'b0;
            s1_parity  <= 1'b0;
            s1_cw      <= '0;
            s1_syn     <= '0;
        end else begin
            if (in_ready_o) begin
                s1_valid <= in_valid_i;
            end
            if (in_fire) begin
                s1_cw      <= codeword_i;
                s1_corr_en <= corr_en_i;
                s1_syn     <= in_syn;
                s1_parity  <= in_parity;
            end
        end
    end

    // Odd overall parity with an in-range syndrome is one flipped bit;
    // anything else nonzero cannot be corrected.
    always_comb begin
        s1_class = ERR_NONE;
        if (s1_parity && (int'(s1_syn) <= CW_W - 1)) begin
            s1_class = ERR_SINGLE;
        end else if (s1_parity || (s1_syn != '0)) begin
            s1_class = ERR_DOUBLE;
        end
        corr_cw = s1_cw;
        if ((s1_class == ERR_SINGLE) && s1_corr_en) begin
            corr_cw[s1_syn] = ~s1_cw[s1_syn];
        end
        s1_data = DATA_W'(extract_data(MAX_CW'(corr_cw), CW_W));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_o  <= 1'b0;
            data_o       <= '0;
            err_single_o <= 1'b0;
            err_double_o <= 1'b0;
            syndrome_o   <= '0;
        end else if (s2_open) begin
            out_valid_o <= s1_valid;
            if (s1_valid) begin
                data_o       <= s1_data;
                err_single_o <= (s1_class == ERR_SINGLE);
                err_double_o <= (s1_class == ERR_DOUBLE);
                syndrome_o   <= s1_syn;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_corr_o   <= '0;
            cnt_uncorr_o <= '0;
        end else if (clr_cnt_i) begin
            cnt_corr_o   <= '0;
            cnt_uncorr_o <= '0;
        end else if (out_fire) begin
            if (err_single_o && (cnt_corr_o != '1)) begin
                cnt_corr_o <= cnt_corr_o + 1'b1;
            end
            if (err_double_o && (cnt_uncorr_o != '1)) begin
                cnt_uncorr_o <= cnt_uncorr_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_module_hamming_secded_stream.sv
// Bench for the streaming SECDED decoder (DATA_W=4, CNT_W=2): vector table,
// backpressure/counter/reset sequences and a randomized stream vs. a model.
module tb_module_hamming_secded_stream;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] codeword;
    logic       corr_en;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] data;
    logic       err_single;
    logic       err_double;
    logic [2:0] syndrome;
    logic [1:0] cnt_corr;
    logic [1:0] cnt_uncorr;
    logic       clr_cnt;

    int checks = 0;
    int failures = 0;

    // Expected result layout: {data[3:0], single, double, syndrome[2:0]}
    logic [8:0] exp_q[$];
    int         occ;
    logic [1:0] m_cnt_corr;
    logic [1:0] m_cnt_uncorr;
    logic       held;
    logic [8:0] held_val;
    logic       rand_done;

    typedef struct packed {
        logic [7:0] cw;
        logic       ce;
        logic [8:0] exp;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    module_hamming_secded_stream #(
        .DATA_W(4),
        .CNT_W (2)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .codeword_i  (codeword),
        .corr_en_i   (corr_en),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (data),
        .err_single_o(err_single),
        .err_double_o(err_double),
        .syndrome_o  (syndrome),
        .cnt_corr_o  (cnt_corr),
        .cnt_uncorr_o(cnt_uncorr),
        .clr_cnt_i   (clr_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [7:0] c;
        c    = '0;
        c[3] = d[0];
        c[5] = d[1];
        c[6] = d[2];
        c[7] = d[3];
        c[1] = d[0] ^ d[1] ^ d[3];
        c[2] = d[0] ^ d[2] ^ d[3];
        c[4] = d[1] ^ d[2] ^ d[3];
        c[0] = ^c[7:1];
        return c;
    endfunction

    function automatic logic [3:0] raw_data(input logic [7:0] cw);
        return {cw[7], cw[6], cw[5], cw[3]};
    endfunction

    // Decode by nearest valid codeword; the syndrome is the XOR of the
    // positions that differ from it.
    function automatic logic [8:0] model(input logic [7:0] cw, input logic ce);
        int         best_dist;
        logic [3:0] best_d;
        logic [7:0] diff;
        logic [2:0] s;
        best_dist = 99;
        best_d    = '0;
        for (int d = 0; d < 16; d++) begin
            if ($countones(cw ^ enc(4'(d))) < best_dist) begin
                best_dist = $countones(cw ^ enc(4'(d)));
                best_d    = 4'(d);
            end
        end
        diff = cw ^ enc(best_d);
        s    = '0;
        for (int i = 0; i < 8; i++) begin
            if (diff[i]) s = s ^ 3'(i);
        end
        if (best_dist == 0) return {best_d, 1'b0, 1'b0, 3'd0};
        if (best_dist == 1) return {(ce ? best_d : raw_data(cw)), 1'b1, 1'b0, s};
        return {raw_data(cw), 1'b0, 1'b1, s};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            exp_q.delete();
            occ          = 0;
            m_cnt_corr   = '0;
            m_cnt_uncorr = '0;
            held         = 1'b0;
        end else begin
            chk("cnt_corr", 32'(cnt_corr), 32'(m_cnt_corr));
            chk("cnt_uncorr", 32'(cnt_uncorr), 32'(m_cnt_uncorr));
            chk("in_ready", 32'(in_ready), 32'(!(!out_ready && occ == 2)));
            if (held) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_hold", 32'({data, err_single, err_double, syndrome}), 32'(held_val));
            end
            held     = out_valid && !out_ready;
            held_val = {data, err_single, err_double, syndrome};
            e        = '0;
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_word", 32'({data, err_single, err_double, syndrome}), 32'(e));
                end
                occ--;
            end
            if (clr_cnt) begin
                m_cnt_corr   = '0;
                m_cnt_uncorr = '0;
            end else begin
                if (e[4] && m_cnt_corr != 2'd3) m_cnt_corr++;
                if (e[3] && m_cnt_uncorr != 2'd3) m_cnt_uncorr++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(codeword, corr_en));
                occ++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] cw, input logic ce);
        int n;
        in_valid = 1'b1;
        codeword = cw;
        corr_en  = ce;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Single word with out_ready high: checks latency and result fields.
    task automatic apply_vec(input vec_t v);
        codeword = v.cw;
        corr_en  = v.ce;
        in_valid = 1'b1;
        @(negedge clk);
        chk("vec_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("vec_lat_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("vec_lat_valid", 32'(out_valid), 32'd1);
        chk("vec_result", 32'({data, err_single, err_double, syndrome}), 32'(v.exp));
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [5:0] pat;
        logic       saw_stall;
        logic [7:0] cw;
        int         nf;
        int         q1;
        int         q2;
        int         n;

        vecs[0] = '{8'hAA, 1'b1, {4'b1011, 1'b0, 1'b0, 3'd0}};
        vecs[1] = '{8'h8A, 1'b1, {4'b1011, 1'b1, 1'b0, 3'd5}};
        vecs[2] = '{8'h8A, 1'b0, {4'b1001, 1'b1, 1'b0, 3'd5}};
        vecs[3] = '{8'hAB, 1'b1, {4'b1011, 1'b1, 1'b0, 3'd0}};
        vecs[4] = '{8'hCA, 1'b1, {4'b1101, 1'b0, 1'b1, 3'd3}};
        vecs[5] = '{8'h66, 1'b1, {4'b0110, 1'b0, 1'b0, 3'd0}};
        vecs[6] = '{8'h67, 1'b0, {4'b0110, 1'b1, 1'b0, 3'd0}};
        vecs[7] = '{8'h6E, 1'b1, {4'b0110, 1'b1, 1'b0, 3'd3}};
        vecs[8] = '{8'h6E, 1'b0, {4'b0111, 1'b1, 1'b0, 3'd3}};

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        codeword  = '0;
        corr_en   = 1'b0;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        rand_done = 1'b0;

        // reset state
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_flags", 32'({err_single, err_double}), 32'd0);
        chk("rst_syndrome", 32'(syndrome), 32'd0);
        chk("rst_counters", 32'({cnt_corr, cnt_uncorr}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // vector table
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            apply_vec(vecs[i]);
        end

        // continuous stream under toggling backpressure
        pat       = 6'b101001;
        saw_stall = 1'b0;
        fork
            begin
                send(8'hAA, 1'b1);
                send(8'h8A, 1'b1);
                send(8'hCA, 1'b1);
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    out_ready = pat[i];
                    @(negedge clk);
                    if (!in_ready) saw_stall = 1'b1;
                    @(posedge clk);
                    #1;
                end
            end
        join
        chk("bp_in_ready_fell", 32'(saw_stall), 32'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // counter saturation, then clear against a simultaneous increment
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) send(8'h8A, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt_corr", 32'(cnt_corr), 32'd3);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'h8A, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("clr_pre_valid", 32'(out_valid), 32'd1);
        clr_cnt   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_wins", 32'(cnt_corr), 32'd0);
        @(posedge clk);
        #1;

        // asynchronous reset mid-stream
        codeword = 8'h8A;
        corr_en  = 1'b1;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_cnt_nonzero", 32'(cnt_corr != 2'd0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_cnts", 32'({cnt_corr, cnt_uncorr}), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_vec(vecs[1]);

        // randomized stream against the model
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    cw = enc(4'($urandom_range(0, 15)));
                    nf = $urandom_range(0, 2);
                    q1 = $urandom_range(0, 7);
                    q2 = (q1 + $urandom_range(1, 7)) % 8;
                    if (nf >= 1) cw = cw ^ (8'd1 << q1);
                    if (nf == 2) cw = cw ^ (8'd1 << q2);
                    send(cw, 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join

        // drain
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_occ", 32'(occ), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/module_hamming_secded_stream.md
Name: module_hamming_secded_stream

Overview:
Parametrised, pipelined SECDED (extended Hamming) decoder/corrector for codeword streams.
- Successor to the fixed 7,4 combinational detector/corrector/decoder chain.
- Generalised data width, with an added overall-parity bit for double-error detection.
- Valid/ready handshake with backpressure, detect-only mode, and saturating error-statistics counters.
- Sits between the codeword source (switches/link) and the LED/7-segment/error display drivers.

Parameters:
- DATA_W, 4: data bits per word. Legal values are 4, 11, 26, 57.
- PAR_W, derived: Hamming parity bits. Smallest r with 2^r >= DATA_W+r+1. Equals 3 for DATA_W=4.
- CW_W, derived: DATA_W+PAR_W+1, codeword width. Equals 8 for DATA_W=4.
- CNT_W, 8: width of the error-statistics counters.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  codeword valid.
- in_ready_o  out  1  block can accept a codeword.
- codeword_i  in  CW_W  bit 0 is overall parity; bit k (1..CW_W-1) is Hamming position k.
- corr_en_i  in  1  1 = correct single errors; 0 = detect only. Sampled with each codeword.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- data_o  out  DATA_W  extracted data, in ascending non-power-of-two positions (position 3 = data_o[0]).
- err_single_o  out  1  single-bit error detected (corrected if corr_en).
- err_double_o  out  1  uncorrectable error detected.
- syndrome_o  out  PAR_W  Hamming syndrome of this word.
- cnt_corr_o  out  CNT_W  saturating count of single-error words.
- cnt_uncorr_o  out  CNT_W  saturating count of double-error words.
- clr_cnt_i  in  1  synchronous clear of both counters.

Behaviour:
- Reset:
  - All valids are 0.
  - data_o, syndrome_o, both flags and both counters are 0.
  - Reset asserted mid-operation discards in-flight words.
- Pipeline:
  - Two register stages.
  - S1 captures the codeword and corr_en, and registers the syndrome plus overall parity p (XOR of all CW_W bits).
  - S2 registers the classification, corrected word, extracted data and flags.
  - Latency is 2 cycles from input handshake to out_valid_o when out_ready_i is high.
  - Throughput is 1 word/cycle.
- Handshake:
  - A stage loads when it is empty or its content advances this cycle.
  - in_ready_o = !s1_valid | s1_advance. A combinational ready path is permitted.
  - While out_valid_o=1 and out_ready_i=0, all outputs hold stable and no word is lost or duplicated.
  - in_valid_i is ignored when in_ready_o=0.
- Classification (s = syndrome):
  - s=0, p=0: no error.
  - p=1 and s<=CW_W-1: single error at position s. s=0 means the parity bit itself is in error; data is unaffected.
  - p=0 and s!=0: double error; err_double_o=1.
  - p=1 and s>CW_W-1 (possible only when non-full): err_double_o=1.
  - err_single_o and err_double_o are never both 1.
- Correction:
  - With corr_en=1 and a single error, bit s is flipped before data extraction.
  - With corr_en=0, or on a double error, data is extracted raw.
  - Flags and syndrome are reported regardless of mode.
- Counters:
  - A counter increments on the output handshake (out_valid_o & out_ready_i) when the matching flag is set.
  - Counters saturate at 2^CNT_W-1.
  - clr_cnt_i wins over a simultaneous increment.

Decomposition:
- Package pkg_secded holds:
  - function par_w(DATA_W)
  - function is_pow2(pos)
  - function extract_data(codeword)
  - typedef err_class_t {ERR_NONE, ERR_SINGLE, ERR_DOUBLE}
- Sub-module module_secded_syndrome: combinational syndrome and overall-parity computation, parametrised by CW_W. It is reusable by a future streaming encoder.

Test Plan:
1. DATA_W=4, codeword 8'hAA, corr_en=1, out_ready high: after 2 cycles, data_o=4'b1011, no flags, syndrome 0, counters 0.
2. Codeword 8'h8A (position 5 flipped), corr_en=1: data_o=4'b1011, err_single_o=1, syndrome_o=5, cnt_corr_o=1. Repeat with corr_en=0: data_o=4'b1001, flags unchanged.
3. Codeword 8'hAB (parity bit flipped): data_o=4'b1011, err_single_o=1, syndrome_o=0. Codeword 8'hCA (positions 5 and 6 flipped): err_double_o=1, syndrome_o=3, cnt_uncorr_o increments.
4. Backpressure: stream 8'hAA, 8'h8A, 8'hCA continuously while out_ready_i toggles 1,0,0,1,0,1. Outputs appear in order, unchanged while stalled, no loss or duplication, and in_ready_o falls when both stages are full.
5. Counter saturation and clear: CNT_W=2, five single-error words give cnt_corr_o=3. clr_cnt_i asserted on the same cycle as an error handshake gives cnt_corr_o=0.
6. Assert rst_n_i low asynchronously mid-stream: out_valid_o and counters go to 0 immediately. After release, the first new word emerges with latency 2.
